// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, with a handshake on every memory access and a retirement counter.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        RegDst,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    IEXEC   = 4'd10,
    IWB     = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t     state_q;
  state_t     state_d;
  logic [15:0] count_q;

  assign state       = state_q;
  assign instr_count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // An instruction retires on any entry into FETCH from elsewhere; FETCH stalls do not count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   count_q <= 16'd0;
    else if (state_d == FETCH && state_q != FETCH) count_q <= count_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      state_d = MEMADR;
          OP_RTYPE:                          state_d = EXEC;
          OP_BEQ:                            state_d = BRANCH;
          OP_J:                              state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
          default:                           state_d = HALT;
        endcase
      end
      // An opcode that is neither lw nor sw here can only be corruption; stop safely.
      MEMADR: begin
        if (opcode == OP_LW)      state_d = MEMRD;
        else if (opcode == OP_SW) state_d = MEMWR;
        else                      state_d = HALT;
      end
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      EXEC:    state_d = RTYPEWB;
      IEXEC:   state_d = IWB;
      MEMWB, RTYPEWB, IWB, BRANCH, JUMP: state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Strobes are held low for the whole time reset is high, even though state already reads FETCH.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        RTYPEWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
        end
        IWB:     RegWrite = 1'b1;
        HALT:    halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port opcode  input  6  instruction bits 31:26, taken from the instruction register.
REQ-004 SHALL have port mem_ready  input  1  memory handshake; high means the current memory access completes this cycle.
REQ-005 SHALL have output ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, each 1 bit, each a datapath control strobe.
REQ-006 SHALL have output ports ALUOp, ALUSrcB and PCSource, each 2 bits, each a datapath mux or ALU-control select.
REQ-007 SHALL have port state  output  4  current state encoding, for debug and the bench.
REQ-008 SHALL have port halted  output  1  high while in HALT.
REQ-009 SHALL have port instr_count  output  16  count of retired instructions.

Function
REQ-010 SHALL be a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, HALT=12.
REQ-011 SHALL use these opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, slti 001010.
REQ-012 SHALL take these transitions:
- FETCH: stays while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: lw/sw to MEMADR; R-type to EXEC; beq to BRANCH; j to JUMP; immediate ops to IEXEC; any other opcode to HALT.
- MEMADR: lw to MEMRD; sw to MEMWR.
- MEMRD: stays while mem_ready=0; goes to MEMWB when mem_ready=1.
- MEMWR: stays while mem_ready=0; goes to FETCH when mem_ready=1.
- EXEC to RTYPEWB; IEXEC to IWB.
- MEMWB, RTYPEWB, IWB, BRANCH and JUMP go to FETCH.
- HALT stays in HALT until reset.
REQ-013 SHALL drive, in each state, only the listed strobes (non-zero values shown); all other outputs 0:
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: MemRead=1, IorD=1.
- MEMWR: MemWrite=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- RTYPEWB: RegWrite=1, RegDst=1, MemtoReg=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11 (ALU control decodes the opcode).
- IWB: RegWrite=1, RegDst=0, MemtoReg=0.
- HALT: all strobes 0, halted=1.
REQ-014 SHALL never assert MemRead and MemWrite in the same cycle, and SHALL never assert RegWrite outside MEMWB, RTYPEWB and IWB.
REQ-015 SHALL, with mem_ready held at 1, take these cycle counts FETCH-to-FETCH: R-type 4, lw 5, sw 4, beq 3, j 3, immediate 4; each cycle mem_ready is low adds one cycle.
REQ-016 SHALL sample opcode only in DECODE and MEMADR; opcode changes in other states have no effect.
REQ-017 SHALL increment instr_count by 1 on every transition into FETCH from a non-FETCH state, wrapping 0xFFFF to 0x0000; it SHALL NOT increment while in HALT or while FETCH stalls.

Reset
REQ-018 SHALL, while reset=1, immediately force state=FETCH (0), instr_count=0, halted=0 and every control strobe to 0, independent of clk.
REQ-019 SHALL, after reset deasserts, drive the FETCH outputs of REQ-013 from the next cycle; reset asserted mid-instruction SHALL abandon that instruction without incrementing instr_count.

Verification
REQ-020 SHALL be verified by: reset, mem_ready=1, opcode=000000 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; instr_count=1.
REQ-021 SHALL be verified by: lw (100011) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 for all three MEMRD cycles; MemtoReg=1 in state 4.
REQ-022 SHALL be verified by: FETCH with mem_ready=0 for 3 cycles -> state stays 0 with IRWrite=0 and PCWrite=0; on the first mem_ready=1 cycle IRWrite=1 and PCWrite=1.
REQ-023 SHALL be verified by: opcode 111111 at DECODE -> state 12, halted=1, all strobes 0 for 10+ cycles; asserting reset then returns state to 0 and halted to 0.
REQ-024 SHALL be verified by: preloading 65535 retirements, then a j (000010) -> states 0,1,9,0; PCWrite=1 and PCSource=10 in state 9; instr_count wraps to 0.
REQ-025 SHALL be verified by: reset asserted mid-instruction in MEMWR -> state=0 and MemWrite=0 within the same cycle, with instr_count unchanged from its reset value of 0.
